// File: rtl/release_queue.sv
`default_nettype none
// ============================================================================
//  Module      : release_queue
//  Description : Buffers physical-resource indices freed at retire and turns
//                them into the one-hot `clear` vector consumed by the
//                resource allocator. Accepts up to NUM_RETIRE frees per cycle
//                (all-or-nothing backpressure via rel_ready) and drains up to
//                DRAIN_WIDTH entries per cycle into a registered clear vector.
//  Options     : RELQ_BYPASS_EN - when defined, a small group (1..DRAIN_WIDTH
//                valid lanes) arriving at an empty queue is ORed straight into
//                clear at the same edge (1-cycle latency) without storage.
//  Ports       :
//     clock      in   single clock, all state updates on posedge
//     reset      in   asynchronous, active-high
//     rel_valid  in   [NUM_RETIRE]          per-lane release valid
//     rel_idx    in   [NUM_RETIRE][IDX_W]   per-lane index being freed
//     rel_ready  out  room for a full NUM_RETIRE-lane group this cycle
//     clear      out  [NUM_RESOURCES]       registered OR of drained indices
//     count      out  [$clog2(DEPTH)+1]     registered occupancy
//     empty      out  count == 0
//     full       out  count == DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module release_queue #(
   parameter  int NUM_RESOURCES = 64,
   parameter  int NUM_RETIRE    = 3,
   parameter  int DEPTH         = 16,
   parameter  int DRAIN_WIDTH   = 2,
   localparam int IDX_W         = $clog2(NUM_RESOURCES),
   localparam int CNT_W         = $clog2(DEPTH) + 1
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [NUM_RETIRE-1:0]             rel_valid,
   input  logic [NUM_RETIRE-1:0][IDX_W-1:0]  rel_idx,
   output logic                              rel_ready,
   output logic [NUM_RESOURCES-1:0]          clear,
   output logic [CNT_W-1:0]                  count,
   output logic                              empty,
   output logic                              full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]         head_q, head_d;
   logic [PTR_W-1:0]         tail_q, tail_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic [NUM_RESOURCES-1:0] clear_q, clear_d;
   logic [IDX_W-1:0]         mem_q [DEPTH];
   logic [IDX_W-1:0]         mem_d [DEPTH];

   logic [CNT_W-1:0]         space;
   logic [CNT_W-1:0]         ndrain;
   logic [CNT_W-1:0]         nvalid;
   logic [CNT_W-1:0]         nenq;
   logic [PTR_W-1:0]         rd_ptr;
   logic [PTR_W-1:0]         wr_ptr;
   logic [IDX_W-1:0]         rd_idx;
   logic                     bypass;
   logic                     enq_en;

   // Occupancy-derived controls; all from registered count only, so
   // rel_ready never depends on the same-cycle drain.
   always_comb begin
      space     = CNT_W'(DEPTH) - count_q;
      rel_ready = (space >= CNT_W'(NUM_RETIRE));
      if (count_q < CNT_W'(DRAIN_WIDTH)) begin
         ndrain = count_q;
      end else begin
         ndrain = CNT_W'(DRAIN_WIDTH);
      end
   end

   always_comb begin
      nvalid = '0;
      for (int l = 0; l < NUM_RETIRE; l++) begin
         if (rel_valid[l]) begin
            nvalid = nvalid + CNT_W'(1);
         end
      end
   end

`ifdef RELQ_BYPASS_EN
   // Empty queue plus a group small enough to retire in one drain slot:
   // skip storage and feed clear directly.
   assign bypass = (count_q == '0) && (nvalid != '0) &&
                   (nvalid <= CNT_W'(DRAIN_WIDTH));
`else
   assign bypass = 1'b0;
`endif

   assign enq_en = rel_ready & ~bypass;

   always_comb begin
      mem_d   = mem_q;
      clear_d = '0;
      nenq    = '0;
      rd_ptr  = head_q;
      wr_ptr  = tail_q;
      rd_idx  = '0;

      // Drain window covers only entries present before the edge, so it can
      // never overlap the slots being written at tail in the same cycle.
      for (int d = 0; d < DRAIN_WIDTH; d++) begin
         if (CNT_W'(d) < ndrain) begin
            rd_ptr = head_q + PTR_W'(d);
            rd_idx = mem_q[rd_ptr];
            // Out-of-range indices still consume their drain slot.
            if (int'(rd_idx) < NUM_RESOURCES) begin
               clear_d[rd_idx] = 1'b1;
            end
         end
      end

      if (bypass) begin
         for (int l = 0; l < NUM_RETIRE; l++) begin
            if (rel_valid[l] && (int'(rel_idx[l]) < NUM_RESOURCES)) begin
               clear_d[rel_idx[l]] = 1'b1;
            end
         end
      end

      // Compact valid lanes in ascending order; pointer arithmetic wraps
      // naturally at the PTR_W boundary since DEPTH is a power of two.
      if (enq_en) begin
         for (int l = 0; l < NUM_RETIRE; l++) begin
            if (rel_valid[l]) begin
               wr_ptr        = tail_q + nenq[PTR_W-1:0];
               mem_d[wr_ptr] = rel_idx[l];
               nenq          = nenq + CNT_W'(1);
            end
         end
      end

      head_d  = head_q + ndrain[PTR_W-1:0];
      tail_d  = tail_q + nenq[PTR_W-1:0];
      count_d = count_q + nenq - ndrain;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         clear_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         clear_q <= clear_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   assign clear = clear_q;
   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_release_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_release_queue
//  Description : Scoreboard bench for release_queue. Stimulus pushes the
//                hand-computed clear words it expects; a negedge monitor pops
//                one word per non-zero clear cycle and compares. Occupancy and
//                handshake outputs are checked directly by the stimulus.
//                Honours RELQ_BYPASS_EN when the design is built with it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_release_queue;

   logic              clock;
   logic              reset;
   logic [2:0]        rel_valid;
   logic [2:0][5:0]   rel_idx;
   logic              rel_ready;
   logic [63:0]       clear;
   logic [4:0]        count;
   logic              empty;
   logic              full;

   int                errors = 0;
   int                checks = 0;
   logic [63:0]       exp_q[$];
   logic [63:0]       mon_exp;

   release_queue dut (
      .clock     (clock),
      .reset     (reset),
      .rel_valid (rel_valid),
      .rel_idx   (rel_idx),
      .rel_ready (rel_ready),
      .clear     (clear),
      .count     (count),
      .empty     (empty),
      .full      (full)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [63:0] b1(int i);
      logic [63:0] one;
      one = 64'd1;
      return one << i;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(logic [2:0] v, int a, int b, int c);
      rel_valid  = v;
      rel_idx[0] = 6'(a);
      rel_idx[1] = 6'(b);
      rel_idx[2] = 6'(c);
   endtask

   task automatic sb_drained(string name);
      step();
      step();
      chk(name, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic wait_empty(string name);
      int n;
      n = 0;
      while (count != 5'd0 && n < 100) begin
         step();
         n++;
      end
      chk(name, 64'(count), 64'd0);
   endtask

   // Three-lane group into an empty queue: two drain cycles.
   task automatic group3(string name, int a, int b, int c,
                         logic [63:0] e1, logic [63:0] e2);
      drive(3'b111, a, b, c);
      exp_q.push_back(e1);
      exp_q.push_back(e2);
      step();
      drive(3'b000, 0, 0, 0);
      chk({name, "_cnt_e0"}, 64'(count), 64'd3);
      step();
      chk({name, "_cnt_e1"}, 64'(count), 64'd1);
      step();
      chk({name, "_cnt_e2"}, 64'(count), 64'd0);
      sb_drained({name, "_sb"});
   endtask

   // Monitor: every non-zero clear cycle must match the next expected word.
   always @(negedge clock) begin
      if (!reset && clear !== 64'd0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL clear_unexpected: got %0h expected none", clear);
         end else begin
            mon_exp = exp_q.pop_front();
            if (clear !== mon_exp) begin
               errors++;
               $display("FAIL clear_word: got %0h expected %0h", clear, mon_exp);
            end
         end
      end
   end

   initial begin
      #200000;
      errors++;
      checks++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      int g;
      int cyc;
      logic acc;
      logic saw14;

      reset = 1'b1;
      drive(3'b000, 0, 0, 0);
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      // Reset state
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_clear", clear, 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_ready", 64'(rel_ready), 64'd1);

      // Single release of index 5
      drive(3'b001, 5, 0, 0);
      exp_q.push_back(b1(5));
      step();
      drive(3'b000, 0, 0, 0);
`ifdef RELQ_BYPASS_EN
      chk("single_byp_cnt", 64'(count), 64'd0);
      step();
`else
      chk("single_cnt_e0", 64'(count), 64'd1);
      step();
      chk("single_cnt_e1", 64'(count), 64'd0);
`endif
      sb_drained("single_sb");

      // Burst {10,11,12}: two per cycle then the remainder
      group3("burst", 10, 11, 12, b1(10) | b1(11), b1(12));

      // Duplicate index in one drain group ORs together
      group3("dup", 9, 9, 4, b1(9), b1(4));

      // Reset mid-burst: 7 groups raise count to 9; pairs drained so far
      for (int j = 0; j < 6; j++) exp_q.push_back(b1(2*j) | b1(2*j+1));
      for (int k = 0; k < 7; k++) begin
         drive(3'b111, 3*k, 3*k+1, 3*k+2);
         step();
      end
      drive(3'b000, 0, 0, 0);
      chk("mid_cnt9", 64'(count), 64'd9);
      @(negedge clock);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_count", 64'(count), 64'd0);
      chk("mid_rst_clear", clear, 64'd0);
      chk("mid_rst_ready", 64'(rel_ready), 64'd1);
      chk("mid_rst_empty", 64'(empty), 64'd1);
      @(posedge clock);
      #1 reset = 1'b0;
      chk("mid_sb", 64'(exp_q.size()), 64'd0);
      step();
      step();
      chk("mid_post_clear", clear, 64'd0);
      chk("mid_post_count", 64'(count), 64'd0);

      // Backpressure: 26 groups (indices k mod 64 for k = 0..77) presented
      // back to back; count saturates at 14 and groups are held.
      for (int j = 0; j < 39; j++) exp_q.push_back(b1((2*j) % 64) | b1((2*j+1) % 64));
      g = 0;
      cyc = 0;
      saw14 = 1'b0;
      while (g < 26 && cyc < 300) begin
         drive(3'b111, (3*g) % 64, (3*g+1) % 64, (3*g+2) % 64);
         chk("bp_ready", 64'(rel_ready), 64'(count <= 5'd13));
         if (count == 5'd14) begin
            saw14 = 1'b1;
            chk("bp_full_at14", 64'(full), 64'd0);
         end
         acc = rel_ready;
         step();
         if (acc) g++;
         cyc++;
      end
      drive(3'b000, 0, 0, 0);
      chk("bp_accepted", 64'(g), 64'd26);
      chk("bp_saw14", 64'(saw14), 64'd1);
      wait_empty("bp_drain");
      sb_drained("bp_sb");

      // Wrap-around: 78 entries since reset leave head = tail = 14
      group3("wrap", 1, 2, 3, b1(1) | b1(2), b1(3));

`ifdef RELQ_BYPASS_EN
      // Two-lane group on empty queue bypasses storage
      drive(3'b011, 7, 8, 0);
      exp_q.push_back(b1(7) | b1(8));
      step();
      drive(3'b000, 0, 0, 0);
      chk("byp_cnt", 64'(count), 64'd0);
      sb_drained("byp_sb");
      // Three-lane group on empty queue is stored normally
      group3("byp3", 30, 31, 32, b1(30) | b1(31), b1(32));
`endif

      chk("final_empty", 64'(empty), 64'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/release_queue.md
Name: release_queue

Overview:
- Buffers physical-resource indices freed at retire and turns them into the one-hot `clear` vector consumed by the resource allocator.
- Sits directly upstream of the allocator: retire/commit → release_queue → allocator.clear.
- Absorbs retire bursts of up to NUM_RETIRE frees per cycle and drains them at up to DRAIN_WIDTH per cycle.
- Applies all-or-nothing backpressure to retire.

Parameters:
- NUM_RESOURCES, 64, number of allocatable resources; width of `clear`.
- NUM_RETIRE, 3, release lanes per cycle from retire.
- DEPTH, 16, queue entries; power of 2, ≥ NUM_RETIRE, ≥ DRAIN_WIDTH.
- DRAIN_WIDTH, 2, maximum indices converted to `clear` bits per cycle.
- IDX_W, $clog2(NUM_RESOURCES), derived index width; not overridden.

Ports:
- clock  in  1  single clock; all state updates on posedge clock.
- reset  in  1  asynchronous, active-high.
- rel_valid  in  NUM_RETIRE  per-lane release valid.
- rel_idx  in  NUM_RETIRE x IDX_W  per-lane resource index being freed.
- rel_ready  out  1  queue can accept a full NUM_RETIRE-lane group this cycle.
- clear  out  NUM_RESOURCES  registered one-hot-OR of drained indices; drives allocator `clear`.
- count  out  $clog2(DEPTH)+1  current occupancy, registered.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- Reset (asynchronous, active-high): head = 0, tail = 0, count = 0, clear = 0. As a result empty = 1, full = 0, rel_ready = 1. Any in-flight queue contents are discarded.
- rel_ready is combinational from registered count: rel_ready = (DEPTH − count) ≥ NUM_RETIRE. It does not depend on the same-cycle drain.
- Enqueue: only when rel_ready = 1. Valid lanes are compacted in ascending lane order and written at tail, tail+1, …; invalid lanes consume no slot. tail advances by popcount(rel_valid), modulo DEPTH.
- When rel_ready = 0, rel_valid is ignored entirely. Retire must hold the group and re-present it.
- Drain: each cycle ndrain = min(count, DRAIN_WIDTH), using pre-edge count. Entries head … head+ndrain−1 are popped. At the edge, clear is loaded with the OR of their one-hot decodes; clear is 0 when ndrain = 0. head advances by ndrain, modulo DEPTH.
- clear is held for exactly one cycle per drained group, then recomputed.
- Latency: an index sampled with rel_valid at edge E0 is stored at E0. At the earliest it is popped at E1, and clear shows its bit in the cycle after E1. Minimum latency is 2 cycles.
- Ordering is FIFO across groups and lane order within a group.
- Simultaneous enqueue and drain: count_next = count + popcount(accepted lanes) − ndrain. Write and read never alias, because the drain window only covers pre-edge entries.
- Wrap-around: compaction and drain indexing are computed modulo DEPTH. A group straddling entry DEPTH−1 → 0 must be handled correctly.
- Duplicate indices within one drain group: the bits are ORed with no error. Upstream must not double-free.
- Out-of-range index (≥ NUM_RESOURCES): consumes a slot and a drain slot, but sets no clear bit.
- full: no enqueue is possible, since rel_ready = 0 whenever DEPTH − count < NUM_RETIRE. Drain continues normally.
- empty: clear goes 0 on the next edge. Pointers are not reset.

Optional Feature:
- Macro: RELQ_BYPASS_EN.
- Defined: the bypass condition is count == 0 and 1 ≤ popcount(rel_valid) ≤ DRAIN_WIDTH. When it holds, the valid lanes skip storage and are ORed straight into clear at that edge, giving 1-cycle latency. tail and count are unchanged. When the condition does not hold, enqueue proceeds as normal.
- Undefined: no bypass path; minimum latency is 2 cycles as above.

Test Plan:
- Reset mid-burst: fill to count = 9, assert reset asynchronously between edges → count = 0, clear = 0 and rel_ready = 1 immediately, before the next edge. No stale bits appear after reset deasserts.
- Single release, bypass off: rel_valid = 3'b001, rel_idx[0] = 5 at E0 → clear = 1<<5 for exactly one cycle after E1; count reads 1 after E0 and 0 after E1.
- Burst drain, DRAIN_WIDTH = 2: group {10, 11, 12} at E0 → clear = bits {10, 11} after E1, then bit {12} after E2, then 0.
- Backpressure/full: present 3-lane groups every cycle without drain stalls until count = 14 → rel_ready = 0. The held group is accepted only once count ≤ 13; the drained index sequence matches input order exactly.
- Wrap-around: pre-position head = tail = 14, enqueue {1, 2, 3} → entries land in slots 14, 15, 0. clear sequence is {1, 2} then {3}; count returns to 0.
- Bypass, RELQ_BYPASS_EN defined: on an empty queue, present rel_valid = 3'b011 with indices {7, 8} → clear = bits {7, 8} in the cycle after E0 and count stays 0. A 3-lane group on an empty queue is enqueued normally instead.
